fifo_stream_reader: RTL

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Purpose  : Reads a burst of 'len' bytes from a synchronous FIFO (1-cycle
//            read latency) and forwards them on a valid/ready byte stream
//            through a 3-entry output buffer.
// Options  : define FSR_PARITY_EN to add out_parity (XOR of out_data).
// Revision : 1.0  initial release
// ============================================================================
module fifo_stream_reader (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] len,
  output logic       fifo_rd_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rd_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       done
`ifdef FSR_PARITY_EN
  ,
  output logic       out_parity
`endif
);

  localparam logic [4:0] c_max_len   = 5'd16;
  localparam logic [2:0] c_buf_depth = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_len;
  logic [4:0]  r_issued;
  logic [4:0]  r_delivered;
  logic        r_inflight;     // a read was issued last cycle; data arrives now
  logic [7:0]  r_buf [0:2];    // r_buf[0] is the stream head
  logic [7:0]  w_buf_nxt [0:2];
  logic [1:0]  r_count;
  logic [1:0]  w_count_nxt;
  logic [1:0]  w_wr_idx;
  logic        r_parity;
  logic [4:0]  w_len_clamped;
  logic [2:0]  w_pending;
  logic        w_rd_en;
  logic        w_push;
  logic        w_pop;
  logic        w_last_xfer;

  // Burst length saturates at 16 words.
  assign w_len_clamped = (len > c_max_len) ? c_max_len : len;

  // Words already buffered plus the one possibly in flight must leave room.
  assign w_pending = {1'b0, r_count} + {2'b00, r_inflight};

  // Read strobe: only in RUN, never on an empty FIFO, never past len, never
  // when the buffer could overflow, and never while reset is held.
  assign w_rd_en = (r_state == S_RUN) && !fifo_empty && (r_issued < r_len) &&
                   (w_pending < c_buf_depth) && !rst;

  assign w_push      = r_inflight;
  assign w_pop       = out_valid && out_ready;
  assign w_last_xfer = w_pop && ((r_delivered + 5'd1) == r_len);

  // Outputs are held at their reset values while rst is asserted.
  assign fifo_rd_en = w_rd_en;
  assign out_valid  = (r_count != 2'd0) && !rst;
  assign out_data   = rst ? 8'h00 : r_buf[0];
  assign busy       = (r_state != S_IDLE) && !rst;
  assign done       = (r_state == S_DONE) && !rst;
`ifdef FSR_PARITY_EN
  assign out_parity = rst ? 1'b0 : r_parity;
`endif

  // Next-state logic for the burst sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (w_len_clamped == 5'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (r_issued == r_len) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_last_xfer) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output buffer update: pop shifts toward the head, push lands after the
  // last surviving entry.
  always_comb begin
    w_buf_nxt   = r_buf;
    w_count_nxt = r_count;
    w_wr_idx    = r_count;
    if (w_pop) begin
      w_buf_nxt[0] = r_buf[1];
      w_buf_nxt[1] = r_buf[2];
      w_wr_idx     = r_count - 2'd1;
    end
    if (w_push) begin
      case (w_wr_idx)
        2'd0:    w_buf_nxt[0] = fifo_rd_data;
        2'd1:    w_buf_nxt[1] = fifo_rd_data;
        2'd2:    w_buf_nxt[2] = fifo_rd_data;
        default: w_buf_nxt[2] = r_buf[2];
      endcase
    end
    w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
  end

  // State, counters, in-flight flag and buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_len       <= 5'd0;
      r_issued    <= 5'd0;
      r_delivered <= 5'd0;
      r_inflight  <= 1'b0;
      r_count     <= 2'd0;
      r_parity    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_buf[i] <= 8'h00;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_rd_en;
      r_count    <= w_count_nxt;
      r_buf      <= w_buf_nxt;
      r_parity   <= ^w_buf_nxt[0];
      if (r_state == S_IDLE && start) begin
        r_len       <= w_len_clamped;
        r_issued    <= 5'd0;
        r_delivered <= 5'd0;
      end else begin
        if (w_rd_en) begin
          r_issued <= r_issued + 5'd1;
        end
        if (w_pop) begin
          r_delivered <= r_delivered + 5'd1;
        end
      end
    end
  end

`ifndef FSR_PARITY_EN
  // Parity register exists only for the optional output; keep it referenced.
  logic w_parity_unused;
  assign w_parity_unused = r_parity;
`endif

endmodule
`default_nettype wire
